// File: rtl/spi_pkg.sv
// Shared SPI definitions: minion state encoding and the default packet width
// agreed with the SPI master.
package spi_pkg;

    localparam int SPI_NBITS_DEFAULT = 34;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        CHECK  = 2'd2
    } minion_state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop pin synchroniser with rise/fall pulse detection against a
// one-cycle delayed copy of the synchronised value.
module spi_sync_edge #(
    parameter int   DEPTH   = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic q,
    output logic rise,
    output logic fall
);

    logic [DEPTH-1:0] chain_reg;
    logic             dly_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain_reg <= {DEPTH{RST_VAL}};
            dly_reg   <= RST_VAL;
        end else begin
            chain_reg <= {chain_reg[DEPTH-2:0], din};
            dly_reg   <= chain_reg[DEPTH-1];
        end
    end

    assign q    = chain_reg[DEPTH-1];
    assign rise = q & ~dly_reg;
    assign fall = ~q & dly_reg;

endmodule

// File: rtl/spi_minion.sv
// SPI mode-0 follower: oversampled pins, nbits rx packets on a val/rdy port,
// one buffered tx word per transaction. SPI_MINION_SYNC3_EN deepens pin syncs to 3.
module spi_minion
    import spi_pkg::*;
#(
    parameter int nbits = SPI_NBITS_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cs,
    input  logic             sclk,
    input  logic             mosi,
    output logic             miso,
    output logic             recv_val,
    input  logic             recv_rdy,
    output logic [nbits-1:0] recv_msg,
    input  logic             send_val,
    output logic             send_rdy,
    input  logic [nbits-1:0] send_msg,
    output logic             overflow,
    output logic             frame_err
);

`ifdef SPI_MINION_SYNC3_EN
    localparam int SYNC_DEPTH = 3;
`else
    localparam int SYNC_DEPTH = 2;
`endif
    localparam int CW = $clog2(nbits + 2);

    // Reset asserts asynchronously but releases on a clock edge.
    logic [1:0] rst_sync_reg;
    logic       rst_n_int;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) rst_sync_reg <= 2'b00;
        else        rst_sync_reg <= {rst_sync_reg[0], 1'b1};
    end
    assign rst_n_int = rst_sync_reg[1];

    // Pin index: 0 = mosi, 1 = sclk, 2 = cs (cs idles high).
    logic [2:0] pin_in, pin_s, pin_rise, pin_fall;
    assign pin_in = {cs, sclk, mosi};

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_pin_sync
            spi_sync_edge #(
                .DEPTH   (SYNC_DEPTH),
                .RST_VAL ((gi == 2) ? 1'b1 : 1'b0)
            ) u_sync (
                .clk   (clk),
                .rst_n (rst_n_int),
                .din   (pin_in[gi]),
                .q     (pin_s[gi]),
                .rise  (pin_rise[gi]),
                .fall  (pin_fall[gi])
            );
        end
    endgenerate

    logic mosi_s, sclk_rise, sclk_fall, cs_rise, cs_fall;
    assign mosi_s    = pin_s[0];
    assign sclk_rise = pin_rise[1];
    assign sclk_fall = pin_fall[1];
    assign cs_rise   = pin_rise[2];
    assign cs_fall   = pin_fall[2];

    logic unused_pin_bits;
    assign unused_pin_bits = &{1'b0, pin_rise[0], pin_fall[0], pin_s[2:1]};

    minion_state_t    state_reg;
    logic [CW-1:0]    bit_cnt_reg;
    logic [nbits-1:0] rx_shift_reg;
    logic [nbits-1:0] tx_shift_reg;
    logic [nbits-1:0] tx_hold_reg;
    logic             tx_full_reg;

    assign send_rdy = !tx_full_reg;

    always_ff @(posedge clk or negedge rst_n_int) begin
        if (!rst_n_int) begin
            state_reg    <= IDLE;
            bit_cnt_reg  <= '0;
            rx_shift_reg <= '0;
            tx_shift_reg <= '0;
            tx_hold_reg  <= '0;
            tx_full_reg  <= 1'b0;
            miso         <= 1'b0;
            recv_val     <= 1'b0;
            recv_msg     <= '0;
            overflow     <= 1'b0;
            frame_err    <= 1'b0;
        end else begin
            // Consumer handshake retires the word; a CHECK reload below overrides.
            if (recv_val && recv_rdy) recv_val <= 1'b0;

            if (send_val && !tx_full_reg) begin
                tx_hold_reg <= send_msg;
                tx_full_reg <= 1'b1;
            end

            case (state_reg)
                IDLE: begin
                    if (cs_fall) begin
                        state_reg    <= ACTIVE;
                        bit_cnt_reg  <= '0;
                        rx_shift_reg <= '0;
                        if (tx_full_reg) begin
                            tx_shift_reg <= tx_hold_reg;
                            miso         <= tx_hold_reg[nbits-1];
                            tx_full_reg  <= 1'b0;
                        end else begin
                            tx_shift_reg <= '0;
                            miso         <= 1'b0;
                        end
                    end
                end
                ACTIVE: begin
                    if (sclk_rise) begin
                        rx_shift_reg <= {rx_shift_reg[nbits-2:0], mosi_s};
                        if (bit_cnt_reg != CW'(nbits + 1))
                            bit_cnt_reg <= bit_cnt_reg + 1'b1;
                    end
                    if (sclk_fall) begin
                        tx_shift_reg <= {tx_shift_reg[nbits-2:0], 1'b0};
                        miso         <= tx_shift_reg[nbits-2];
                    end
                    if (cs_rise) state_reg <= CHECK;
                end
                CHECK: begin
                    state_reg <= IDLE;
                    miso      <= 1'b0;
                    if (bit_cnt_reg != CW'(nbits)) begin
                        frame_err <= 1'b1;
                    end else if (!recv_val || recv_rdy) begin
                        recv_msg <= rx_shift_reg;
                        recv_val <= 1'b1;
                    end else begin
                        overflow <= 1'b1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_minion.sv
// Directed + randomized bench for spi_minion against a transaction-level model
// of delivered packets, sticky flags and miso response bits.
module tb_spi_minion;

    localparam int NB = 34;
`ifdef SPI_MINION_SYNC3_EN
    localparam int LAT = 5;
`else
    localparam int LAT = 4;
`endif
    localparam int HALF = 6;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          cs = 1'b1;
    logic          sclk = 1'b0;
    logic          mosi = 1'b0;
    logic          miso;
    logic          recv_val;
    logic          recv_rdy = 1'b0;
    logic [NB-1:0] recv_msg;
    logic          send_val = 1'b0;
    logic          send_rdy;
    logic [NB-1:0] send_msg = '0;
    logic          overflow;
    logic          frame_err;

    spi_minion #(.nbits(NB)) dut (
        .clk       (clk),
        .reset     (reset),
        .cs        (cs),
        .sclk      (sclk),
        .mosi      (mosi),
        .miso      (miso),
        .recv_val  (recv_val),
        .recv_rdy  (recv_rdy),
        .recv_msg  (recv_msg),
        .send_val  (send_val),
        .send_rdy  (send_rdy),
        .send_msg  (send_msg),
        .overflow  (overflow),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int lat_seen;

    bit            val_exp, ovf_exp, fe_exp;
    logic [NB-1:0] msg_exp;
    logic [NB-1:0] exp_q[$];
    logic [NB-1:0] got_q[$];

    always @(negedge clk) if (recv_val && recv_rdy) got_q.push_back(recv_msg);

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic model_reset();
        val_exp = 0; ovf_exp = 0; fe_exp = 0; msg_exp = '0;
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic check_state(input string ctx);
        logic [NB-1:0] g, e;
        $display("txn %s: recv_val=%0b recv_msg=%h ovf=%0b ferr=%0b delivered=%0d",
                 ctx, recv_val, recv_msg, overflow, frame_err, got_q.size());
        chk({ctx, ".recv_val"}, 64'(recv_val), 64'(val_exp));
        chk({ctx, ".recv_msg"}, 64'(recv_msg), 64'(msg_exp));
        chk({ctx, ".overflow"}, 64'(overflow), 64'(ovf_exp));
        chk({ctx, ".frame_err"}, 64'(frame_err), 64'(fe_exp));
        chk({ctx, ".rx_count"}, 64'(got_q.size()), 64'(exp_q.size()));
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            chk({ctx, ".rx_word"}, 64'(g), 64'(e));
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic set_rdy(input logic v, input string ctx);
        @(negedge clk);
        recv_rdy = v;
        if (v && val_exp) begin
            exp_q.push_back(msg_exp);
            val_exp = 0;
        end
        wait_n(3);
        check_state(ctx);
    endtask

    task automatic clock_bit(input logic b);
        mosi = b;
        wait_n(HALF);
        sclk = 1'b1;
        wait_n(HALF);
        sclk = 1'b0;
    endtask

    // One master transaction of nsent bits, optionally preloading a response word.
    task automatic run_xfer(input string ctx, input logic [NB-1:0] word, input int nsent,
                            input bit has_tx, input logic [NB-1:0] txw);
        logic [63:0] mo, me;
        logic        val_before;
        mo = '0; me = '0;
        if (has_tx) begin
            @(negedge clk);
            send_msg = txw; send_val = 1'b1;
            @(negedge clk);
            send_val = 1'b0;
            chk({ctx, ".send_rdy_full"}, 64'(send_rdy), 64'(0));
        end
        cs = 1'b0;
        wait_n(8);
        chk({ctx, ".send_rdy_free"}, 64'(send_rdy), 64'(1));
        for (int i = 0; i < nsent; i++) begin
            mosi = (i < NB) ? word[NB-1-i] : 1'b0;
            wait_n(HALF);
            sclk = 1'b1;
            mo = {mo[62:0], miso};
            me = {me[62:0], (has_tx && i < NB) ? txw[NB-1-i] : 1'b0};
            wait_n(HALF);
            sclk = 1'b0;
        end
        wait_n(HALF);
        val_before = recv_val;
        cs = 1'b1;
        lat_seen = 0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (lat_seen == 0 && !val_before && recv_val) lat_seen = i;
        end
        chk({ctx, ".miso_bits"}, mo, me);
        chk({ctx, ".miso_idle"}, 64'(miso), 64'(0));
        if (nsent != NB) fe_exp = 1;
        else if (val_exp) ovf_exp = 1;
        else begin
            msg_exp = word;
            if (recv_rdy) exp_q.push_back(word);
            else val_exp = 1;
        end
        check_state(ctx);
    endtask

    initial begin
        logic [63:0] r64, t64;
        model_reset();
        wait_n(4);
        chk("rst.miso", 64'(miso), 64'(0));
        chk("rst.recv_val", 64'(recv_val), 64'(0));
        chk("rst.recv_msg", 64'(recv_msg), 64'(0));
        chk("rst.send_rdy", 64'(send_rdy), 64'(1));
        chk("rst.overflow", 64'(overflow), 64'(0));
        chk("rst.frame_err", 64'(frame_err), 64'(0));
        reset = 1'b1;
        wait_n(6);

        set_rdy(1'b1, "rdy_on");
        run_xfer("basic", 34'h2_DEAD_BEEF, NB, 0, '0);
        chk("basic.latency", 64'(lat_seen), 64'(LAT));
        run_xfer("response", 34'h0_0000_ABCD, NB, 1, 34'h1_2345_6789);
        run_xfer("no_resp", 34'h3_C3C3_5A5A, NB, 0, '0);

        set_rdy(1'b0, "bp_rdy_off");
        run_xfer("bp_first", 34'h1, NB, 0, '0);
        run_xfer("bp_second", 34'h2, NB, 1, 34'h2_AAAA_5555);
        set_rdy(1'b1, "bp_drain");

        run_xfer("frame_short", 34'h3_FFFF_0000, 20, 0, '0);
        run_xfer("frame_recover", 34'h3FF, NB, 0, '0);

        // Reset in the middle of a transaction with a response word held.
        cs = 1'b0;
        wait_n(8);
        for (int i = 0; i < 10; i++) begin
            if (i == 5) begin
                send_msg = 34'h3_1234_5678; send_val = 1'b1;
                @(negedge clk);
                send_val = 1'b0;
                chk("midrst.send_rdy_full", 64'(send_rdy), 64'(0));
            end
            clock_bit(1'b1);
        end
        reset = 1'b0;
        #1;
        chk("midrst.miso", 64'(miso), 64'(0));
        chk("midrst.recv_val", 64'(recv_val), 64'(0));
        chk("midrst.recv_msg", 64'(recv_msg), 64'(0));
        chk("midrst.send_rdy", 64'(send_rdy), 64'(1));
        chk("midrst.overflow", 64'(overflow), 64'(0));
        chk("midrst.frame_err", 64'(frame_err), 64'(0));
        cs = 1'b1; sclk = 1'b0; mosi = 1'b0;
        wait_n(3);
        reset = 1'b1;
        model_reset();
        wait_n(6);
        run_xfer("after_rst", 34'h155, NB, 0, '0);

        for (int n = 0; n < 10; n++) begin
            r64 = {$urandom, $urandom};
            t64 = {$urandom, $urandom};
            set_rdy(1'($urandom_range(0, 2) != 0), "rnd_rdy");
            run_xfer("rnd", r64[NB-1:0],
                     ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 40)) : NB,
                     1'($urandom_range(0, 1)), t64[NB-1:0]);
        end
        set_rdy(1'b1, "final_drain");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
